// File: rtl/uart_pkg.sv
// Shared widths, reset divisor and types for the UART fractional baud generator.
package uart_pkg;

  localparam int BAUD_DIV_W        = 16;
  localparam int BAUD_FRAC_W       = 4;
  localparam int BAUD_DIV_INT_RST  = 868;
  localparam int BAUD_DIV_FRAC_RST = 1;

  typedef struct packed {
    logic [BAUD_DIV_W-1:0]  div_int;
    logic [BAUD_FRAC_W-1:0] div_frac;
  } baud_div_t;

  typedef enum logic {
    STRB_END = 1'b0,
    STRB_MID = 1'b1
  } strb_pos_e;

endpackage

// File: rtl/uart_baud_chan.sv
// One baud channel: period down-counter, fractional accumulator, pending divisor
// handling and a strobe at either the end or the middle of each bit period.
module uart_baud_chan
  import uart_pkg::*;
#(
  parameter int        DIV_W        = BAUD_DIV_W,
  parameter int        FRAC_W       = BAUD_FRAC_W,
  parameter int        DIV_INT_RST  = BAUD_DIV_INT_RST,
  parameter int        DIV_FRAC_RST = BAUD_DIV_FRAC_RST,
  parameter strb_pos_e POS          = STRB_END
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              restart,
  input  logic              load,
  input  logic [DIV_W-1:0]  sh_int,
  input  logic [FRAC_W-1:0] sh_frac,
  input  logic [DIV_W-1:0]  sh_int_nxt,
  input  logic [FRAC_W-1:0] sh_frac_nxt,
  output logic              strb,
  output logic              pend_nxt
);

  localparam logic [DIV_W-1:0] ONE_D   = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W:0]   ONE_P   = {{DIV_W{1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] RST_INT = DIV_INT_RST[DIV_W-1:0];
  localparam logic [DIV_W-1:0] RST_CNT = RST_INT - ONE_D;

  logic [DIV_W-1:0]  act_int_r;
  logic [FRAC_W-1:0] act_frac_r;
  logic [FRAC_W-1:0] acc_r;
  logic [DIV_W-1:0]  cnt_r;
  logic [DIV_W:0]    per_r;
  logic              pend_r;
  logic              strb_r;

  logic              idle_s;
  logic              reload_s;
  logic              apply_s;
  logic              hit_s;
  logic [DIV_W-1:0]  int_base_s;
  logic [FRAC_W-1:0] frac_base_s;
  logic [FRAC_W-1:0] acc_base_s;
  logic [FRAC_W:0]   sum_s;
  logic [DIV_W:0]    per_nxt_s;
  logic [DIV_W:0]    cnt_load_s;
  logic              pend_nxt_s;

  // Next-period arithmetic; a pending shadow divisor replaces the active one at the boundary.
  always_comb begin
    idle_s      = !en || restart;
    reload_s    = !idle_s && (cnt_r == '0);
    apply_s     = reload_s && pend_r;
    int_base_s  = apply_s ? sh_int  : act_int_r;
    frac_base_s = apply_s ? sh_frac : act_frac_r;
    acc_base_s  = apply_s ? '0      : acc_r;
    sum_s       = {1'b0, acc_base_s} + {1'b0, frac_base_s};
    per_nxt_s   = {1'b0, int_base_s} + {{DIV_W{1'b0}}, sum_s[FRAC_W]};
    cnt_load_s  = per_nxt_s - ONE_P;
    if (POS == STRB_MID) begin
      hit_s = ({1'b0, cnt_r} == (per_r - (per_r >> 1)));
    end else begin
      hit_s = (cnt_r == '0);
    end
    if (idle_s) begin
      pend_nxt_s = 1'b0;
    end else if (load) begin
      pend_nxt_s = 1'b1;
    end else if (reload_s) begin
      pend_nxt_s = 1'b0;
    end else begin
      pend_nxt_s = pend_r;
    end
  end

  // Channel state: idle follows the shadow, enabled counts down and reloads at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_int_r  <= RST_INT;
      act_frac_r <= DIV_FRAC_RST[FRAC_W-1:0];
      acc_r      <= '0;
      cnt_r      <= RST_CNT;
      per_r      <= {1'b0, RST_INT};
      pend_r     <= 1'b0;
      strb_r     <= 1'b0;
    end else begin
      pend_r <= pend_nxt_s;
      strb_r <= !idle_s && hit_s;
      if (idle_s) begin
        act_int_r  <= sh_int_nxt;
        act_frac_r <= sh_frac_nxt;
        acc_r      <= '0;
        per_r      <= {1'b0, sh_int_nxt};
        cnt_r      <= sh_int_nxt - ONE_D;
      end else if (reload_s) begin
        act_int_r  <= int_base_s;
        act_frac_r <= frac_base_s;
        acc_r      <= sum_s[FRAC_W-1:0];
        per_r      <= per_nxt_s;
        cnt_r      <= cnt_load_s[DIV_W-1:0];
      end else begin
        cnt_r <= cnt_r - ONE_D;
      end
    end
  end

  assign strb     = strb_r;
  assign pend_nxt = pend_nxt_s;

endmodule

// File: rtl/uart_baudgen_frac.sv
// Fractional baud-rate generator: shadow divisor register with clamp, and
// independent TX (bit end) and RX (bit middle) strobe channels.
module uart_baudgen_frac
  import uart_pkg::*;
#(
  parameter int DIV_W        = BAUD_DIV_W,
  parameter int FRAC_W       = BAUD_FRAC_W,
  parameter int DIV_INT_RST  = BAUD_DIV_INT_RST,
  parameter int DIV_FRAC_RST = BAUD_DIV_FRAC_RST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  i_div_int,
  input  logic [FRAC_W-1:0] i_div_frac,
  input  logic              i_div_load,
  input  logic              i_tx_en,
  input  logic              i_rx_en,
  input  logic              i_rx_resync,
  output logic              o_tx_strb,
  output logic              o_rx_strb,
  output logic              o_div_pending
);

  localparam logic [DIV_W-1:0] MIN_DIV = {{(DIV_W-2){1'b0}}, 2'b10};

  logic [DIV_W-1:0]  sh_int_r;
  logic [FRAC_W-1:0] sh_frac_r;
  logic              div_pending_r;

  logic [DIV_W-1:0]  div_int_clamp_s;
  logic [DIV_W-1:0]  sh_int_nxt_s;
  logic [FRAC_W-1:0] sh_frac_nxt_s;
  logic              tx_pend_nxt_s;
  logic              rx_pend_nxt_s;

  // Clamp the integer divisor so a period is never shorter than two clocks.
  always_comb begin
    if (i_div_int < MIN_DIV) begin
      div_int_clamp_s = MIN_DIV;
    end else begin
      div_int_clamp_s = i_div_int;
    end
    if (i_div_load) begin
      sh_int_nxt_s  = div_int_clamp_s;
      sh_frac_nxt_s = i_div_frac;
    end else begin
      sh_int_nxt_s  = sh_int_r;
      sh_frac_nxt_s = sh_frac_r;
    end
  end

  // Shadow divisor and the registered pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_int_r      <= DIV_INT_RST[DIV_W-1:0];
      sh_frac_r     <= DIV_FRAC_RST[FRAC_W-1:0];
      div_pending_r <= 1'b0;
    end else begin
      sh_int_r      <= sh_int_nxt_s;
      sh_frac_r     <= sh_frac_nxt_s;
      div_pending_r <= tx_pend_nxt_s | rx_pend_nxt_s;
    end
  end

  uart_baud_chan #(
    .DIV_W       (DIV_W),
    .FRAC_W      (FRAC_W),
    .DIV_INT_RST (DIV_INT_RST),
    .DIV_FRAC_RST(DIV_FRAC_RST),
    .POS         (STRB_END)
  ) u_tx_chan (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (i_tx_en),
    .restart    (1'b0),
    .load       (i_div_load),
    .sh_int     (sh_int_r),
    .sh_frac    (sh_frac_r),
    .sh_int_nxt (sh_int_nxt_s),
    .sh_frac_nxt(sh_frac_nxt_s),
    .strb       (o_tx_strb),
    .pend_nxt   (tx_pend_nxt_s)
  );

  uart_baud_chan #(
    .DIV_W       (DIV_W),
    .FRAC_W      (FRAC_W),
    .DIV_INT_RST (DIV_INT_RST),
    .DIV_FRAC_RST(DIV_FRAC_RST),
    .POS         (STRB_MID)
  ) u_rx_chan (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (i_rx_en),
    .restart    (i_rx_resync),
    .load       (i_div_load),
    .sh_int     (sh_int_r),
    .sh_frac    (sh_frac_r),
    .sh_int_nxt (sh_int_nxt_s),
    .sh_frac_nxt(sh_frac_nxt_s),
    .strb       (o_rx_strb),
    .pend_nxt   (rx_pend_nxt_s)
  );

  assign o_div_pending = div_pending_r;

endmodule

// File: tb/tb_uart_baudgen_frac.sv
// Directed bench for uart_baudgen_frac: strobe timing, fractional spacing,
// RX resync, pending divisor handoff, clamp and asynchronous reset.
module tb_uart_baudgen_frac;
  import uart_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] i_div_int;
  logic [3:0]  i_div_frac;
  logic        i_div_load;
  logic        i_tx_en;
  logic        i_rx_en;
  logic        i_rx_resync;
  logic        o_tx_strb;
  logic        o_rx_strb;
  logic        o_div_pending;

  int n_checks = 0;
  int n_errors = 0;

  uart_baudgen_frac dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_div_int    (i_div_int),
    .i_div_frac   (i_div_frac),
    .i_div_load   (i_div_load),
    .i_tx_en      (i_tx_en),
    .i_rx_en      (i_rx_en),
    .i_rx_resync  (i_rx_resync),
    .o_tx_strb    (o_tx_strb),
    .o_rx_strb    (o_rx_strb),
    .o_div_pending(o_div_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Count falling edges until the selected strobe is seen; -1 when the budget runs out.
  task automatic wait_strb(input bit rx, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if ((rx ? o_rx_strb : o_tx_strb) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic load_div(input baud_div_t d);
    i_div_int  = d.div_int;
    i_div_frac = d.div_frac;
    i_div_load = 1'b1;
    @(negedge clk);
    i_div_load = 1'b0;
  endtask

  initial begin
    int        n;
    int        total;
    int        cnt;
    int        tx_first;
    int        rx_first;
    baud_div_t d;

    rst_n       = 1'b0;
    i_div_int   = 16'd0;
    i_div_frac  = 4'd0;
    i_div_load  = 1'b0;
    i_tx_en     = 1'b0;
    i_rx_en     = 1'b0;
    i_rx_resync = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_strb", o_tx_strb, 0);
    check_eq("rst_rx_strb", o_rx_strb, 0);
    check_eq("rst_pending", o_div_pending, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // int=10 frac=0: TX strobes every 10 cycles
    d = '{div_int: 16'd10, div_frac: 4'd0};
    load_div(d);
    i_tx_en = 1'b1;
    wait_strb(1'b0, 200, n); check_eq("tx10_first", n, 10);
    wait_strb(1'b0, 200, n); check_eq("tx10_second", n, 10);
    wait_strb(1'b0, 200, n); check_eq("tx10_third", n, 10);

    // load int=20 mid-period: pending until the next TX boundary
    repeat (3) @(negedge clk);
    d = '{div_int: 16'd20, div_frac: 4'd0};
    load_div(d);
    check_eq("pend_set", o_div_pending, 1);
    wait_strb(1'b0, 200, n); check_eq("pend_old_period", n, 6);
    check_eq("pend_clear", o_div_pending, 0);
    wait_strb(1'b0, 200, n); check_eq("pend_new_period", n, 20);
    check_eq("pend_stays_clear", o_div_pending, 0);

    // enable dropped mid-period: no strobe afterwards
    repeat (5) @(negedge clk);
    i_tx_en = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_tx_strb) cnt++;
    end
    check_eq("disable_no_strb", cnt, 0);

    // int=10 frac=8: spacing alternates 10,11; 32 spacings total 336
    d = '{div_int: 16'd10, div_frac: 4'd8};
    load_div(d);
    i_tx_en = 1'b1;
    wait_strb(1'b0, 200, n); check_eq("frac_first", n, 10);
    total = 0;
    for (int k = 0; k < 32; k++) begin
      wait_strb(1'b0, 200, n);
      if (k == 0) check_eq("frac_sp0", n, 10);
      if (k == 1) check_eq("frac_sp1", n, 11);
      total += n;
    end
    check_eq("frac_total32", total, 336);
    i_tx_en = 1'b0;
    repeat (2) @(negedge clk);

    // int=1 is clamped to 2
    d = '{div_int: 16'd1, div_frac: 4'd0};
    load_div(d);
    i_tx_en = 1'b1;
    wait_strb(1'b0, 50, n); check_eq("clamp_first", n, 2);
    wait_strb(1'b0, 50, n); check_eq("clamp_sp0", n, 2);
    wait_strb(1'b0, 50, n); check_eq("clamp_sp1", n, 2);
    i_tx_en = 1'b0;
    repeat (2) @(negedge clk);

    // RX int=16: mid-bit strobes at 8, 24; resync at 30 moves the next one
    d = '{div_int: 16'd16, div_frac: 4'd0};
    load_div(d);
    i_rx_en = 1'b1;
    wait_strb(1'b1, 200, n); check_eq("rx_first", n, 8);
    wait_strb(1'b1, 200, n); check_eq("rx_second", n, 16);
    repeat (6) @(negedge clk);
    i_rx_resync = 1'b1;
    @(negedge clk);
    i_rx_resync = 1'b0;
    wait_strb(1'b1, 200, n); check_eq("rx_after_resync", n, 8);
    wait_strb(1'b1, 200, n); check_eq("rx_resync_period", n, 16);

    // resync landing on the mid-point suppresses that strobe
    repeat (15) @(negedge clk);
    i_rx_resync = 1'b1;
    @(negedge clk);
    check_eq("rx_resync_wins", o_rx_strb, 0);
    i_rx_resync = 1'b0;
    wait_strb(1'b1, 200, n); check_eq("rx_after_mid_resync", n, 8);

    // async reset mid-operation, then reset divisor timing
    d = '{div_int: 16'd10, div_frac: 4'd0};
    i_rx_en = 1'b0;
    load_div(d);
    i_tx_en = 1'b1;
    i_rx_en = 1'b1;
    wait_strb(1'b0, 200, n); check_eq("pre_reset_tx", n, 10);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_tx", o_tx_strb, 0);
    check_eq("async_rst_rx", o_rx_strb, 0);
    check_eq("async_rst_pend", o_div_pending, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tx_first = -1;
    rx_first = -1;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (o_tx_strb && tx_first < 0) tx_first = i;
      if (o_rx_strb && rx_first < 0) rx_first = i;
    end
    check_eq("post_rst_tx_first", tx_first, 868);
    check_eq("post_rst_rx_first", rx_first, 434);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_baudgen_frac.md
# uart_baudgen_frac

Programmable fractional baud-rate generator for the UART core. It replaces the fixed eight-rate divider table with a runtime divisor made of an integer part and a fractional part, and produces independent TX and RX strobes. The RX strobe lands mid-bit and can be resynchronised to a detected start edge. The block sits between the AXI4-Lite register file, which supplies the divisor, and the UART TX/RX shift engines, which consume the strobes.

## Interface
- DIV_W, 16, integer divisor width in clocks.
- FRAC_W, 4, fractional divisor width; one LSB is 1/2^FRAC_W clock.
- DIV_INT_RST, 868, integer divisor after reset (≈115200 baud at 100 MHz).
- DIV_FRAC_RST, 1, fractional divisor after reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_div_int  in  DIV_W  integer clocks per bit
- i_div_frac  in  FRAC_W  fractional clocks per bit
- i_div_load  in  1  one-cycle pulse; latches i_div_int/i_div_frac into shadow
- i_tx_en  in  1  TX strobe enable; low holds TX channel in idle phase
- i_rx_en  in  1  RX strobe enable; low holds RX channel in idle phase
- i_rx_resync  in  1  restart RX bit phase (start-bit edge)
- o_tx_strb  out  1  one-cycle pulse at each TX bit end
- o_rx_strb  out  1  one-cycle pulse at each RX bit middle
- o_div_pending  out  1  shadow divisor not yet applied to an enabled channel

## Operation
- Load: i_div_load copies the inputs to the shadow register. An i_div_int value below 2 is stored as 2. Repeated loads overwrite the shadow; the latest load wins.
- Each channel keeps its own active divisor (int, frac), a down-counter cnt, an accumulator acc[FRAC_W-1:0] and a current period P.
- Idle (en low, or i_rx_resync for RX):
  - Active divisor is taken from the shadow.
  - acc=0, P=int, cnt=P-1.
  - The channel's pending bit is cleared.
- Period reload (en high, cnt==0):
  - {carry,acc'} = acc + frac.
  - P = int + carry, cnt = P-1.
  - If the channel is pending, the shadow is applied first and acc is reset to 0.
- Otherwise, while enabled: cnt decrements by 1 each cycle.
- Average period is int + frac/2^FRAC_W. Example: int=10, frac=8 gives periods 10,11,10,11…
- o_tx_strb pulses on the cycle after TX cnt==0.
- o_rx_strb pulses on the cycle after RX cnt==P-(P>>1). This is floor(P/2) cycles after period start.
- o_div_pending = OR of the per-channel pending bits.

## Timing
- Reset values:
  - o_tx_strb=0, o_rx_strb=0, o_div_pending=0.
  - Shadow and both active divisors = DIV_INT_RST/DIV_FRAC_RST.
  - acc=0, cnt=DIV_INT_RST-1.
- All outputs are registered.
- First o_tx_strb comes exactly P cycles after the first enabled cycle, then once every period.
- First o_rx_strb comes floor(P)/2 cycles after enable or after resync deassertion.
- i_rx_resync asserted together with cnt==0 or the mid-point: resync wins and no strobe is issued.
- i_div_load during a reload cycle: the new value applies at the next boundary, not the current one.
- Enable deasserted mid-period: counter is discarded and no strobe is issued on the following cycle.
- Async reset mid-period: strobes drop immediately and the counters restart from the reset divisor.
- cnt never wraps. The accumulator carry is the only overflow path.

## Structure
- uart_pkg holds DIV_W/FRAC_W defaults and typedef baud_div_t (struct: int, frac).
- Sub-module uart_baud_chan covers one counter, accumulator, pending logic and a strobe-position select (END or MID). It is instantiated twice.
- Top level holds only the shadow register, clamp logic and pending OR.

## Test plan
- Reset, then int=10, frac=0, TX enabled → o_tx_strb at cycles 10, 20, 30.
- int=10, frac=8 → TX strobe spacing alternates 10, 11; over 32 bits the total is exactly 336 cycles.
- int=16, RX enabled at cycle 0 → o_rx_strb at 8, 24, 40. Resync at cycle 30 → next strobe 8 cycles after resync release, with none at 40.
- Load int=20 while TX runs at int=10 → o_div_pending=1 until the next TX boundary, after which spacing is 20 and pending clears.
- Load int=1 → behaves as int=2; strobes every 2 cycles.
- Assert rst_n low mid-period with both channels enabled → outputs 0 asynchronously. After release, the first strobe follows DIV_INT_RST timing.
